// File: rtl/aha_perf_pkg.sv
// Shared types, event indices and register offsets for the AHA stage profiler.
package aha_perf_pkg;

    localparam int NUM_STAGES = 6;
    localparam int NUM_EVENTS = 6;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_WAIT1 = 4'd1,
        ST_S1    = 4'd2,
        ST_S2    = 4'd3,
        ST_S3    = 4'd4,
        ST_S4    = 4'd5,
        ST_S5    = 4'd6,
        ST_S6    = 4'd7,
        ST_DONE  = 4'd8
    } perf_state_t;

    // Bit positions in the packed event vector.
    localparam int EV_PROC_WR  = 0;
    localparam int EV_PROC_RD  = 1;
    localparam int EV_IF_CFG   = 2;
    localparam int EV_CGRA_CFG = 3;
    localparam int EV_G2F      = 4;
    localparam int EV_F2G      = 5;

    typedef logic [2:0] ev_sel_t;

    // Indexed by stage (0 = S1); S6 sits in the MSB slot.
    localparam ev_sel_t [NUM_STAGES-1:0] ACT_SEL = {
        3'(EV_F2G), 3'(EV_IF_CFG), 3'(EV_PROC_WR),
        3'(EV_CGRA_CFG), 3'(EV_IF_CFG), 3'(EV_PROC_WR)};
    localparam ev_sel_t [NUM_STAGES-1:0] EXIT_SEL = {
        3'(EV_PROC_RD), 3'(EV_G2F), 3'(EV_IF_CFG),
        3'(EV_PROC_WR), 3'(EV_CGRA_CFG), 3'(EV_IF_CFG)};

    localparam logic [31:0] OFF_CTRL   = 32'h00;
    localparam logic [31:0] OFF_STATUS = 32'h04;
    localparam logic [31:0] OFF_STAGE  = 32'h08;
    localparam logic [31:0] OFF_BUBBLE = 32'h20;
    localparam logic [31:0] OFF_TOTAL  = 32'h38;

    typedef struct packed {
        logic arm;
        logic clear;
    } ctrl_t;

endpackage

// File: rtl/aha_perf_apb_regs.sv
// APB slave for the profiler: address decode, CTRL strobes, registered read mux.
module aha_perf_apb_regs
    import aha_perf_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter int ADDR_W = 12
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             psel,
    input  logic                             penable,
    input  logic                             pwrite,
    input  logic [ADDR_W-1:0]                paddr,
    input  logic [31:0]                      pwdata,
    input  logic [5:0]                       status,
    input  logic [NUM_STAGES-1:0][CNT_W-1:0] stage,
    input  logic [NUM_STAGES-1:0][CNT_W-1:0] bubble,
    input  logic [CNT_W-1:0]                 total,
    output logic [31:0]                      prdata,
    output logic                             pslverr,
    output ctrl_t                            ctrl
);
    logic [31:0] addr, rdata;
    logic        mapped, setup, access, unused_wdata;

    assign addr         = 32'(paddr);
    assign setup        = psel & ~penable;
    assign access       = psel & penable;
    assign unused_wdata = ^pwdata[31:2];

    // ARM/CLEAR exist only for the access cycle, so they self-clear.
    assign ctrl.arm   = access & pwrite & (addr == OFF_CTRL) & pwdata[0];
    assign ctrl.clear = access & pwrite & (addr == OFF_CTRL) & pwdata[1];

    always_comb begin
        rdata  = '0;
        mapped = (addr == OFF_CTRL) || (addr == OFF_STATUS) || (addr == OFF_TOTAL);
        if (addr == OFF_STATUS) rdata = 32'(status);
        if (addr == OFF_TOTAL)  rdata = 32'(total);
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (addr == OFF_STAGE + 32'(4 * k)) begin
                rdata  = 32'(stage[k]);
                mapped = 1'b1;
            end
            if (addr == OFF_BUBBLE + 32'(4 * k)) begin
                rdata  = 32'(bubble[k]);
                mapped = 1'b1;
            end
        end
    end

    // Captured in the setup cycle so data and error are stable for the whole access cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            prdata  <= '0;
            pslverr <= 1'b0;
        end else if (setup) begin
            prdata  <= rdata;
            pslverr <= ~mapped;
        end else if (!access) begin
            pslverr <= 1'b0;
        end
    end

endmodule

// File: rtl/aha_stage_perf_counter.sv
// Per-stage cycle profiler for the CGRA application flow: FSM, span/bubble counters,
// result registers, and an APB window for firmware.
module aha_stage_perf_counter
    import aha_perf_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter int ADDR_W = 12
) (
    input  logic              CPU_CLK,
    input  logic              CPU_RESET,
    input  logic              PROC_WR_EN,
    input  logic              PROC_RD_EN,
    input  logic              IF_CFG_WR_EN,
    input  logic              CGRA_CFG_G2F_CFG_WR_EN,
    input  logic              STREAM_DATA_VALID_G2F,
    input  logic              STREAM_DATA_VALID_F2G,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic              PERF_IRQ
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    perf_state_t                      state, state_nxt;
    logic [NUM_EVENTS-1:0]            ev;
    logic [CNT_W-1:0]                 elapsed, last_act, last_eff, total;
    logic [NUM_STAGES-1:0][CNT_W-1:0] stage_q, bubble_q;
    logic                             ovf, in_stage, act_hit, exit_hit;
    logic [2:0]                       sidx;
    logic [5:0]                       status;
    ctrl_t                            ctrl;

    assign ev = {STREAM_DATA_VALID_F2G, STREAM_DATA_VALID_G2F, CGRA_CFG_G2F_CFG_WR_EN,
                 IF_CFG_WR_EN, PROC_RD_EN, PROC_WR_EN};

    assign in_stage = (state >= ST_S1) && (state <= ST_S6);
    assign sidx     = in_stage ? 3'(state - ST_S1) : 3'd0;
    assign act_hit  = in_stage && ev[ACT_SEL[sidx]];
    assign exit_hit = in_stage && ev[EXIT_SEL[sidx]];
    // Activity wins over a same-cycle exit, so that cycle closes with zero bubble.
    assign last_eff = act_hit ? elapsed : last_act;
    assign status   = {ovf, state == ST_DONE, state};
    assign PREADY   = 1'b1;

    // Stage encodings are consecutive and S6+1 is DONE, so every exit is an increment.
    always_comb begin
        state_nxt = state;
        if (ctrl.clear)                             state_nxt = ST_IDLE;
        else if (ctrl.arm)                          state_nxt = ST_WAIT1;
        else if (state == ST_WAIT1 && ev[EV_PROC_WR]) state_nxt = ST_S1;
        else if (exit_hit)                          state_nxt = perf_state_t'(state + 4'd1);
    end

    always_ff @(posedge CPU_CLK) begin
        if (CPU_RESET) begin
            state    <= ST_IDLE;
            elapsed  <= '0;
            last_act <= '0;
            total    <= '0;
            stage_q  <= '0;
            bubble_q <= '0;
            ovf      <= 1'b0;
            PERF_IRQ <= 1'b0;
        end else begin
            state    <= state_nxt;
            PERF_IRQ <= (state == ST_S6) && (state_nxt == ST_DONE);
            if (ctrl.clear || ctrl.arm) begin
                elapsed  <= '0;
                last_act <= '0;
                total    <= '0;
                stage_q  <= '0;
                bubble_q <= '0;
                ovf      <= 1'b0;
            end else if (state == ST_WAIT1 && ev[EV_PROC_WR]) begin
                elapsed  <= CNT_W'(1);
                last_act <= '0;
                total    <= CNT_W'(1);
            end else if (in_stage) begin
                if (total == CNT_MAX) ovf <= 1'b1;
                else                  total <= total + CNT_W'(1);
                if (exit_hit) begin
                    stage_q[sidx]  <= last_eff;
                    bubble_q[sidx] <= elapsed - last_eff;
                    elapsed        <= CNT_W'(1);
                    last_act       <= '0;
                end else begin
                    last_act <= last_eff;
                    if (elapsed == CNT_MAX) ovf <= 1'b1;
                    else                    elapsed <= elapsed + CNT_W'(1);
                end
            end
        end
    end

    aha_perf_apb_regs #(
        .CNT_W  (CNT_W),
        .ADDR_W (ADDR_W)
    ) u_regs (
        .clk     (CPU_CLK),
        .rst     (CPU_RESET),
        .psel    (PSEL),
        .penable (PENABLE),
        .pwrite  (PWRITE),
        .paddr   (PADDR),
        .pwdata  (PWDATA),
        .status  (status),
        .stage   (stage_q),
        .bubble  (bubble_q),
        .total   (total),
        .prdata  (PRDATA),
        .pslverr (PSLVERR),
        .ctrl    (ctrl)
    );

endmodule

// File: tb/tb_aha_stage_perf_counter.sv
// Bench for aha_stage_perf_counter: 32-bit and 4-bit instances share stimulus and are
// compared against a timestamp-based reference model.
module tb_aha_stage_perf_counter;

    localparam logic [5:0] E_WR = 6'h01, E_RD = 6'h02, E_IF = 6'h04,
                           E_CG = 6'h08, E_G2F = 6'h10, E_F2G = 6'h20;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  evs;
    logic        psel, penable, pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata [2];
    logic        pready [2];
    logic        pslverr [2];
    logic        irq [2];

    always #5 clk = ~clk;

    aha_stage_perf_counter #(.CNT_W(32), .ADDR_W(12)) dut (
        .CPU_CLK(clk), .CPU_RESET(rst),
        .PROC_WR_EN(evs[0]), .PROC_RD_EN(evs[1]), .IF_CFG_WR_EN(evs[2]),
        .CGRA_CFG_G2F_CFG_WR_EN(evs[3]), .STREAM_DATA_VALID_G2F(evs[4]),
        .STREAM_DATA_VALID_F2G(evs[5]),
        .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
        .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]), .PERF_IRQ(irq[0]));

    aha_stage_perf_counter #(.CNT_W(4), .ADDR_W(12)) dut4 (
        .CPU_CLK(clk), .CPU_RESET(rst),
        .PROC_WR_EN(evs[0]), .PROC_RD_EN(evs[1]), .IF_CFG_WR_EN(evs[2]),
        .CGRA_CFG_G2F_CFG_WR_EN(evs[3]), .STREAM_DATA_VALID_G2F(evs[4]),
        .STREAM_DATA_VALID_F2G(evs[5]),
        .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
        .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]), .PERF_IRQ(irq[1]));

    // Reference model: stage boundaries kept as cycle timestamps, saturated per width.
    longint maxv [2] = '{64'hFFFF_FFFF, 64'd15};
    int     act_ev  [6] = '{0, 2, 3, 0, 2, 5};
    int     exit_ev [6] = '{2, 3, 0, 2, 4, 1};
    int     m_st;
    longint cyc, t_entry, t_last, t_s1;
    longint m_stage [2][6];
    longint m_bub [2][6];
    longint m_tot [2];
    bit     m_ovf [2];
    bit     m_irq;
    int     checks = 0, fails = 0;
    logic [31:0] v, v4;
    bit     rd_err;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic longint sat(longint x, int m);
        return (x > maxv[m]) ? maxv[m] : x;
    endfunction

    task automatic model_clear();
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 6; k++) begin
                m_stage[m][k] = 0;
                m_bub[m][k]   = 0;
            end
            m_tot[m] = 0;
            m_ovf[m] = 0;
        end
    endtask

    task automatic model_clock();
        bit arm, clr;
        int k;
        arm   = psel && penable && pwrite && (paddr == 12'h0) && pwdata[0];
        clr   = psel && penable && pwrite && (paddr == 12'h0) && pwdata[1];
        m_irq = 0;
        if (rst || clr) begin
            model_clear();
            m_st = 0;
        end else if (arm) begin
            model_clear();
            m_st = 1;
        end else if (m_st == 1) begin
            if (evs[0]) begin
                m_st = 2; t_entry = cyc; t_last = cyc; t_s1 = cyc;
                for (int m = 0; m < 2; m++) m_tot[m] = 1;
            end
        end else if (m_st >= 2 && m_st <= 7) begin
            k = m_st - 2;
            for (int m = 0; m < 2; m++) begin
                m_tot[m] = sat(cyc - t_s1 + 1, m);
                if (cyc - t_s1 + 1 > maxv[m]) m_ovf[m] = 1;
            end
            if (evs[act_ev[k]]) t_last = cyc;
            if (evs[exit_ev[k]]) begin
                for (int m = 0; m < 2; m++) begin
                    m_stage[m][k] = sat(t_last - t_entry, m);
                    m_bub[m][k]   = sat(cyc - t_entry, m) - m_stage[m][k];
                end
                m_st++;
                t_entry = cyc; t_last = cyc;
                if (m_st == 8) m_irq = 1;
            end else begin
                for (int m = 0; m < 2; m++)
                    if (cyc - t_entry + 1 > maxv[m]) m_ovf[m] = 1;
            end
        end
        cyc++;
    endtask

    function automatic logic [31:0] mreg(int m, logic [31:0] a);
        if (a == 32'h04) return {26'd0, m_ovf[m], m_st == 8, 4'(m_st)};
        if (a == 32'h38) return 32'(m_tot[m]);
        for (int k = 0; k < 6; k++) begin
            if (a == 32'h08 + 32'(4 * k)) return 32'(m_stage[m][k]);
            if (a == 32'h20 + 32'(4 * k)) return 32'(m_bub[m][k]);
        end
        return 32'd0;
    endfunction

    function automatic bit merr(logic [31:0] a);
        return !((a <= 32'h38) && (a[1:0] == 2'b00));
    endfunction

    task automatic step();
        @(posedge clk);
        model_clock();
        #1;
        chk("irq", 32'(irq[0]), 32'(m_irq));
        chk("irq4", 32'(irq[1]), 32'(m_irq));
    endtask

    task automatic drive(logic [5:0] e);
        evs = e;
        step();
        evs = '0;
    endtask

    task automatic gap(int n);
        repeat (n) step();
    endtask

    task automatic apb_rd(logic [31:0] a, output logic [31:0] d, output logic [31:0] d4);
        logic [31:0] e0, e1;
        bit er;
        evs = '0; psel = 1; penable = 0; pwrite = 0; paddr = a[11:0];
        e0 = mreg(0, a); e1 = mreg(1, a); er = merr(a);
        step();
        penable = 1;
        #1;
        chk($sformatf("rd32@%0h", a), prdata[0], e0);
        chk($sformatf("rd4@%0h", a), prdata[1], e1);
        chk($sformatf("err32@%0h", a), 32'(pslverr[0]), 32'(er));
        chk($sformatf("err4@%0h", a), 32'(pslverr[1]), 32'(er));
        d = prdata[0]; d4 = prdata[1]; rd_err = pslverr[0];
        step();
        psel = 0; penable = 0;
    endtask

    task automatic apb_wr(logic [31:0] a, logic [31:0] d, logic [5:0] e);
        evs = '0; psel = 1; penable = 0; pwrite = 1; paddr = a[11:0]; pwdata = d;
        step();
        penable = 1; evs = e;
        #1;
        chk($sformatf("werr@%0h", a), 32'(pslverr[0]), 32'(merr(a)));
        step();
        psel = 0; penable = 0; pwrite = 0; evs = '0;
    endtask

    task automatic read_all();
        for (int a = 0; a <= 32'h3C; a += 4) apb_rd(32'(a), v, v4);
    endtask

    logic [31:0] exp_stage [5] = '{5, 3, 2, 0, 8};
    logic [31:0] exp_bub   [5] = '{4, 4, 0, 4, 4};

    initial begin
        rst = 1; evs = '0; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
        cyc = 0; m_st = 0; t_entry = 0; t_last = 0; t_s1 = 0; m_irq = 0;
        model_clear();
        gap(2);
        rst = 0;
        chk("pready", 32'(pready[0]), 32'd1);
        chk("pready4", 32'(pready[1]), 32'd1);
        read_all();

        // events before ARM are ignored
        drive(E_WR); drive(E_IF | E_CG); gap(2);
        apb_rd(32'h04, v, v4); chk("idle_status", v, 32'h0);

        // stage 1 only: WR at +0,+1,+4, IF at +10
        apb_wr(32'h00, 32'h1, '0);
        gap(3); drive(E_WR); drive(E_WR); gap(2); drive(E_WR); gap(5); drive(E_IF);
        apb_rd(32'h08, v, v4); chk("stage1", v, 32'd4);
        apb_rd(32'h20, v, v4); chk("bubble12", v, 32'd6);
        apb_rd(32'h04, v, v4); chk("state_s2", v, 32'd3);
        apb_wr(32'h08, 32'hFFFF, '0);
        apb_rd(32'h08, v, v4); chk("stage1_ro", v, 32'd4);
        apb_rd(32'h3C, v, v4); chk("unmapped_data", v, 32'd0); chk("unmapped_err", 32'(rd_err), 32'd1);
        apb_rd(32'h06, v, v4); chk("misaligned_err", 32'(rd_err), 32'd1);

        // full run
        apb_wr(32'h00, 32'h1, '0);
        drive(E_WR); gap(9); drive(E_IF);
        gap(4); drive(E_IF); gap(3); drive(E_CG);
        gap(2); drive(E_CG); gap(3); drive(E_WR);
        gap(1); drive(E_WR | E_IF);
        gap(3); drive(E_G2F);
        drive(E_F2G); gap(6); drive(E_F2G); gap(3); drive(E_RD);
        chk("irq_pulse", 32'(irq[0]), 32'd1);
        step();
        chk("irq_single", 32'(irq[0]), 32'd0);
        for (int k = 0; k < 5; k++) begin
            apb_rd(32'h0C + 32'(4 * k), v, v4); chk($sformatf("stage%0d", k + 2), v, exp_stage[k]);
            apb_rd(32'h24 + 32'(4 * k), v, v4); chk($sformatf("bubble%0d", k + 2), v, exp_bub[k]);
        end
        apb_rd(32'h38, v, v4); chk("total", v, 32'd45); chk("total4", v4, 32'd15);
        apb_rd(32'h04, v, v4); chk("status_done", v, 32'h18); chk("status_done4", v4, 32'h38);

        // saturation on the 4-bit instance
        apb_wr(32'h00, 32'h1, '0);
        drive(E_WR); repeat (20) drive(E_WR); drive(E_IF);
        apb_rd(32'h08, v, v4); chk("sat_stage1", v4, 32'd15); chk("wide_stage1", v, 32'd20);
        apb_rd(32'h04, v, v4); chk("ovf4", 32'(v4[5]), 32'd1);
        apb_wr(32'h00, 32'h1, '0);
        apb_rd(32'h04, v, v4); chk("arm_clears_ovf", v4, 32'h1);

        // reset in S4
        drive(E_WR); drive(E_IF); drive(E_CG); drive(E_WR); gap(1);
        rst = 1; step(); rst = 0;
        apb_rd(32'h04, v, v4); chk("rst_status", v, 32'h0);
        read_all();
        drive(E_WR); gap(1);
        apb_rd(32'h04, v, v4); chk("rst_no_arm", v, 32'h0);

        // ARM colliding with the S3 exit event
        apb_wr(32'h00, 32'h1, '0);
        drive(E_WR); drive(E_IF); gap(1); drive(E_CG); gap(2);
        apb_wr(32'h00, 32'h1, E_WR);
        apb_rd(32'h04, v, v4); chk("arm_wins", v, 32'h1);
        read_all();
        drive(E_WR);
        apb_rd(32'h04, v, v4); chk("rearm_s1", v, 32'h2);

        // randomized runs
        for (int run = 0; run < 10; run++) begin
            apb_wr(32'h00, 32'h1, '0);
            for (int i = 0; i < 80; i++) begin
                int r;
                logic [5:0] e;
                r = $urandom_range(0, 99);
                e = '0;
                for (int b = 0; b < 6; b++) if ($urandom_range(0, 4) == 0) e[b] = 1'b1;
                if (r < 4)       apb_rd(32'($urandom_range(0, 16)) << 2, v, v4);
                else if (r == 4) apb_rd(32'($urandom_range(0, 4095)), v, v4);
                else if (r == 5) apb_wr(32'h00, 32'($urandom_range(1, 2)), e);
                else             drive(e);
            end
            read_all();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
